// File: rtl/rtmc_multi_ctrl_if.sv
`default_nettype none
// ============================================================================
// rtmc_multi_ctrl_if : register bus between decoder (master) and controller
// Revision 1.0
// ============================================================================
interface rtmc_multi_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdat;
   logic              reg_wr;
   logic              reg_rd;
   logic [DATA_W-1:0] reg_rdat;
   logic              reg_ack;

   modport master (
      output reg_addr, reg_wdat, reg_wr, reg_rd,
      input  reg_rdat, reg_ack
   );

   modport slave (
      input  reg_addr, reg_wdat, reg_wr, reg_rd,
      output reg_rdat, reg_ack
   );
endinterface
`default_nettype wire

// File: rtl/rtmc_multi_ctrl.sv
`default_nettype none
// ============================================================================
// rtmc_multi_ctrl : N_CH independent stepper sequencers behind one register bus
// Revision 1.0
// ============================================================================
module rtmc_multi_ctrl #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int N_CH     = 2,
   parameter int MC_W     = 4,
   parameter int MC_DEPTH = 8,
   parameter int CNT_W    = 2 * DATA_W
) (
   input  logic                   clk,
   input  logic                   rst,
   rtmc_multi_ctrl_if.slave       bus,
   output logic [N_CH*MC_W-1:0]   mc,
   output logic [N_CH*MC_W-1:0]   mc_oe,
   output logic                   irq
);
   localparam int PG_W  = ADDR_W - 5;
   localparam int IDX_W = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;
   localparam logic [DATA_W-1:0] C_ID       = DATA_W'(16'h0242);
   localparam logic [DATA_W-1:0] C_UNMAPPED = DATA_W'(16'hEEEE);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   logic [PG_W-1:0]        w_page;
   logic [4:0]             w_off;
   logic                   w_pg0;
   logic [N_CH-1:0]        w_run_vec, w_done_vec, w_ie_vec, w_ch_hit;
   logic [N_CH*DATA_W-1:0] w_ch_rdat;
   logic [DATA_W-1:0]      w_rdat, r_rdat;
   logic                   r_ack;

   assign w_page = bus.reg_addr[ADDR_W-1:5];
   assign w_off  = bus.reg_addr[4:0];
   assign w_pg0  = (w_page == '0);

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      localparam logic [PG_W-1:0] C_PAGE = PG_W'(c + 1);

      state_t            r_state, w_state_nxt;
      logic              r_run, r_done, r_ie, r_ss;
      logic              w_run_nxt, w_done_nxt, w_ss_nxt, w_step;
      logic [IDX_W-1:0]  r_idx, w_idx_step;
      logic [3:0]        r_last, r_size;
      logic [MC_W-1:0]   r_oe;
      logic [CNT_W-1:0]  r_delay, r_target, r_pos, r_dcnt, r_rem;
      logic [CNT_W-1:0]  w_dcnt_nxt, w_rem_nxt, w_size_ext;
      logic [MC_W-1:0]   r_tab [MC_DEPTH];
      logic [5:0]        w_s;
      logic              w_wr, w_ctrl_wr, w_run_req, w_done_clr, w_ie_wr, w_pos_clr, w_tab_ok;
      logic [DATA_W-1:0] w_rd_val;
      logic              w_rd_hit;

      assign w_wr       = bus.reg_wr && (w_page == C_PAGE);
      assign w_ctrl_wr  = w_wr && (w_off == 5'd0);
      // Effective RUN bit this cycle: a write of the RUN register takes effect at once
      assign w_run_req  = (bus.reg_wr && w_pg0 && (w_off == 5'd1)) ? bus.reg_wdat[c] : r_run;
      assign w_done_clr = bus.reg_wr && w_pg0 && (w_off == 5'd2) && bus.reg_wdat[c];
      assign w_ie_wr    = bus.reg_wr && w_pg0 && (w_off == 5'd3);
      assign w_pos_clr  = w_wr && ((w_off == 5'd6) || (w_off == 5'd7));
      assign w_tab_ok   = 32'(w_off[3:0]) < MC_DEPTH;
      assign w_size_ext = {{(CNT_W-4){r_size[3]}}, r_size};

      // Signed wrap of idx + step_size into [0, table_last)
      always_comb begin
         w_s        = 6'(r_idx) + {{2{r_size[3]}}, r_size};
         w_idx_step = '0;
         if (r_last == 4'd0)
            w_idx_step = '0;
         else if (w_s[5])
            w_idx_step = IDX_W'(w_s + 6'(r_last));
         else if (w_s[4:0] >= {1'b0, r_last})
            w_idx_step = IDX_W'(w_s - 6'(r_last));
         else
            w_idx_step = IDX_W'(w_s);
      end

      always_comb begin
         w_state_nxt = r_state;
         w_run_nxt   = w_run_req;
         w_done_nxt  = r_done & ~w_done_clr;
         w_dcnt_nxt  = r_dcnt;
         w_rem_nxt   = r_rem;
         w_step      = 1'b0;
         w_ss_nxt    = 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_run_req) begin
                  w_state_nxt = ST_RUN;
                  w_dcnt_nxt  = r_delay;
                  w_rem_nxt   = r_target;
               end else begin
                  w_step   = r_ss;
                  w_ss_nxt = w_ctrl_wr && bus.reg_wdat[14];
               end
            end
            ST_RUN: begin
               if (!w_run_req) begin
                  w_state_nxt = ST_IDLE;
               end else if (r_dcnt == '0) begin
                  w_step     = 1'b1;
                  w_dcnt_nxt = r_delay;
                  // rem==0 means an unbounded move
                  if (r_rem != '0) begin
                     w_rem_nxt = r_rem - 1'b1;
                     if (r_rem == CNT_W'(1)) begin
                        w_run_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                     end
                  end
               end else begin
                  w_dcnt_nxt = r_dcnt - 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst)
            r_state <= ST_IDLE;
         else
            r_state <= w_state_nxt;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_run    <= 1'b0;
            r_done   <= 1'b0;
            r_ie     <= 1'b0;
            r_ss     <= 1'b0;
            r_idx    <= '0;
            r_pos    <= '0;
            r_dcnt   <= '0;
            r_rem    <= '0;
            r_last   <= '0;
            r_size   <= '0;
            r_oe     <= '0;
            r_delay  <= '0;
            r_target <= '0;
         end else begin
            r_run  <= w_run_nxt;
            r_done <= w_done_nxt;
            r_ss   <= w_ss_nxt;
            r_dcnt <= w_dcnt_nxt;
            r_rem  <= w_rem_nxt;
            if (w_ie_wr)
               r_ie <= bus.reg_wdat[c];
            if (w_step)
               r_idx <= w_idx_step;
            if (w_pos_clr)
               r_pos <= '0;
            else if (w_step)
               r_pos <= r_pos + w_size_ext;
            if (w_wr) begin
               case (w_off)
                  5'd0: begin
                     r_last <= bus.reg_wdat[7:4];
                     r_size <= bus.reg_wdat[3:0];
                  end
                  5'd1: r_oe <= bus.reg_wdat[MC_W-1:0];
                  5'd2: r_delay[CNT_W-1:DATA_W]  <= bus.reg_wdat;
                  5'd3: r_delay[DATA_W-1:0]      <= bus.reg_wdat;
                  5'd4: r_target[CNT_W-1:DATA_W] <= bus.reg_wdat;
                  5'd5: r_target[DATA_W-1:0]     <= bus.reg_wdat;
                  default: ;
               endcase
            end
         end
      end

      always_ff @(posedge clk) begin
         if (w_wr && w_off[4] && w_tab_ok)
            r_tab[w_off[IDX_W-1:0]] <= bus.reg_wdat[MC_W-1:0];
      end

      always_comb begin
         w_rd_hit = 1'b1;
         w_rd_val = '0;
         if (w_off[4]) begin
            w_rd_hit = w_tab_ok;
            w_rd_val = DATA_W'(r_tab[w_off[IDX_W-1:0]]);
         end else begin
            case (w_off[3:0])
               4'd0: w_rd_val = DATA_W'({r_last, r_size});
               4'd1: w_rd_val = DATA_W'(r_oe);
               4'd2: w_rd_val = r_delay[CNT_W-1:DATA_W];
               4'd3: w_rd_val = r_delay[DATA_W-1:0];
               4'd4: w_rd_val = r_target[CNT_W-1:DATA_W];
               4'd5: w_rd_val = r_target[DATA_W-1:0];
               4'd6: w_rd_val = r_pos[CNT_W-1:DATA_W];
               4'd7: w_rd_val = r_pos[DATA_W-1:0];
               4'd8: w_rd_val = DATA_W'({(r_state == ST_RUN), 4'(r_idx)});
               default: w_rd_hit = 1'b0;
            endcase
         end
      end

      assign w_run_vec[c]                   = r_run;
      assign w_done_vec[c]                  = r_done;
      assign w_ie_vec[c]                    = r_ie;
      assign w_ch_hit[c]                    = w_rd_hit;
      assign w_ch_rdat[c*DATA_W +: DATA_W]  = w_rd_val;
      assign mc[c*MC_W +: MC_W]             = r_tab[r_idx];
      assign mc_oe[c*MC_W +: MC_W]          = r_oe;
   end

   always_comb begin
      w_rdat = C_UNMAPPED;
      if (w_pg0) begin
         case (w_off)
            5'd0: w_rdat = C_ID;
            5'd1: w_rdat = DATA_W'(w_run_vec);
            5'd2: w_rdat = DATA_W'(w_done_vec);
            5'd3: w_rdat = DATA_W'(w_ie_vec);
            default: w_rdat = C_UNMAPPED;
         endcase
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if ((w_page == PG_W'(c + 1)) && w_ch_hit[c])
               w_rdat = w_ch_rdat[c*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack  <= 1'b0;
         r_rdat <= '0;
      end else begin
         r_ack <= bus.reg_wr | bus.reg_rd;
         if (bus.reg_rd)
            r_rdat <= w_rdat;
      end
   end

   assign bus.reg_ack  = r_ack;
   assign bus.reg_rdat = r_rdat;
   assign irq          = |(w_done_vec & w_ie_vec);

endmodule
`default_nettype wire

// File: tb/tb_rtmc_multi_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rtmc_multi_ctrl : directed and randomized checks of rtmc_multi_ctrl
// Revision 1.0
// ============================================================================
module tb_rtmc_multi_ctrl;
   logic       clk;
   logic       rst;
   logic [7:0] mc;
   logic [7:0] mc_oe;
   logic       irq;
   int         n_tests;
   int         n_fail;

   rtmc_multi_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   rtmc_multi_ctrl #(
      .ADDR_W(8), .DATA_W(16), .N_CH(2), .MC_W(4), .MC_DEPTH(8), .CNT_W(32)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .mc    (mc),
      .mc_oe (mc_oe),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] A(input int page, input int off);
      return 8'((page << 5) | off);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // All bus tasks start and end just after a falling edge
   task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
      bus.reg_addr = a;
      bus.reg_wdat = d;
      bus.reg_wr   = 1'b1;
      @(negedge clk);
      bus.reg_wr   = 1'b0;
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [15:0] d);
      bus.reg_addr = a;
      bus.reg_rd   = 1'b1;
      @(negedge clk);
      bus.reg_rd   = 1'b0;
      check("rd_ack", 32'(bus.reg_ack), 1);
      d = bus.reg_rdat;
   endtask

   task automatic read_pos(input int ch, output logic [31:0] p);
      logic [15:0] hi, lo;
      bus_rd(A(ch + 1, 6), hi);
      bus_rd(A(ch + 1, 7), lo);
      p = {hi, lo};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] d;
      logic [31:0] p;
      int          tab [8];
      int          ch, last, size, dly, tgt, oe, idx, exp_idx;

      n_tests = 0;
      n_fail  = 0;
      clk = 1'b0;
      rst = 1'b1;
      bus.reg_addr = '0;
      bus.reg_wdat = '0;
      bus.reg_wr   = 1'b0;
      bus.reg_rd   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(bus.reg_ack), 0);
      check("rst_rdat", 32'(bus.reg_rdat), 0);
      check("rst_mc_oe", 32'(mc_oe), 0);
      check("rst_irq", 32'(irq), 0);
      rst = 1'b0;

      // Register map basics
      bus_rd(A(0, 0), d);  check("id", 32'(d), 32'h0242);
      @(negedge clk);      check("ack_pulse", 32'(bus.reg_ack), 0);
      bus_rd(A(0, 4), d);  check("unmap_p0", 32'(d), 32'hEEEE);
      bus_rd(A(1, 9), d);  check("unmap_ch", 32'(d), 32'hEEEE);
      bus_rd(A(3, 0), d);  check("unmap_pg", 32'(d), 32'hEEEE);
      bus_rd(A(1, 24), d); check("unmap_tab", 32'(d), 32'hEEEE);
      bus_rd(A(0, 1), d);  check("run_rst", 32'(d), 0);

      // Bounded move on ch0: table 1,2,4,8, DELAY=2, TARGET=3
      tab[0] = 1; tab[1] = 2; tab[2] = 4; tab[3] = 8;
      for (int i = 0; i < 4; i++) bus_wr(A(1, 16 + i), 16'(tab[i]));
      bus_wr(A(1, 0), 16'h0041);
      bus_wr(A(1, 3), 16'd2);
      bus_wr(A(1, 5), 16'd3);
      bus_wr(A(1, 1), 16'h000F);
      bus_wr(A(0, 3), 16'h0001);
      bus_wr(A(0, 1), 16'h0001);
      for (int t = 0; t <= 10; t++) begin
         exp_idx = (t / 3 > 3) ? 3 : t / 3;
         check("move_mc", 32'(mc[3:0]), tab[exp_idx]);
         check("move_irq", 32'(irq), (t >= 9) ? 1 : 0);
         @(negedge clk);
      end
      check("move_oe", 32'(mc_oe[3:0]), 32'hF);
      bus_rd(A(0, 2), d);  check("move_done", 32'(d), 1);
      bus_rd(A(0, 1), d);  check("move_run", 32'(d), 0);
      read_pos(0, p);      check("move_pos", p, 3);
      bus_rd(A(1, 8), d);  check("move_stat", 32'(d), 3);
      bus_wr(A(0, 2), 16'h0001);
      check("w1c_irq", 32'(irq), 0);

      // Single step backwards from idx 0
      do_reset();
      bus_wr(A(1, 0), 16'h404F);
      @(negedge clk);
      bus_rd(A(1, 8), d);  check("ss1_stat", 32'(d), 3);
      read_pos(0, p);      check("ss1_pos", p, 32'hFFFF_FFFF);
      bus_wr(A(1, 0), 16'h404F);
      @(negedge clk);
      bus_rd(A(1, 8), d);  check("ss2_stat", 32'(d), 2);
      read_pos(0, p);      check("ss2_pos", p, 32'hFFFF_FFFE);
      bus_rd(A(0, 2), d);  check("ss_no_done", 32'(d), 0);

      // Two free-running channels, stopped after 8 cycles
      do_reset();
      bus_wr(A(1, 0), 16'h0041);
      bus_wr(A(2, 0), 16'h0041);
      bus_wr(A(2, 3), 16'd3);
      bus_wr(A(0, 1), 16'h0003);
      repeat (8) @(negedge clk);
      bus_wr(A(0, 1), 16'h0000);
      read_pos(0, p);      check("dual_pos0", p, 8);
      read_pos(1, p);      check("dual_pos1", p, 2);
      repeat (3) @(negedge clk);
      read_pos(0, p);      check("dual_hold0", p, 8);
      read_pos(1, p);      check("dual_hold1", p, 2);

      // W1C of DONE on the cycle of the final step: set must win
      bus_wr(A(1, 3), 16'd2);
      bus_wr(A(1, 5), 16'd1);
      bus_wr(A(0, 3), 16'h0001);
      bus_wr(A(0, 1), 16'h0001);
      repeat (2) @(negedge clk);
      bus_wr(A(0, 2), 16'h0001);
      read_pos(0, p);      check("race_pos", p, 9);
      bus_rd(A(0, 1), d);  check("race_run", 32'(d), 0);
      bus_rd(A(0, 2), d);  check("race_done", 32'(d), 1);
      check("race_irq", 32'(irq), 1);

      // Reset in the middle of a run
      bus_wr(A(1, 1), 16'h000F);
      bus_wr(A(0, 1), 16'h0002);
      repeat (5) @(negedge clk);
      do_reset();
      check("mid_ack", 32'(bus.reg_ack), 0);
      check("mid_rdat", 32'(bus.reg_rdat), 0);
      check("mid_mc_oe", 32'(mc_oe), 0);
      check("mid_irq", 32'(irq), 0);
      repeat (2) @(negedge clk);
      bus_rd(A(0, 1), d);  check("mid_run", 32'(d), 0);
      bus_rd(A(2, 8), d);  check("mid_stat", 32'(d), 0);
      read_pos(1, p);      check("mid_pos", p, 0);

      // Randomized bounded moves against an arithmetic model
      for (int tr = 0; tr < 8; tr++) begin
         do_reset();
         ch   = $urandom_range(0, 1);
         last = $urandom_range(2, 8);
         size = $urandom_range(1, last - 1);
         if ($urandom_range(0, 1) == 1) size = -size;
         dly  = $urandom_range(0, 4);
         tgt  = $urandom_range(1, 6);
         oe   = $urandom_range(1, 15);
         for (int i = 0; i < 8; i++) begin
            tab[i] = $urandom_range(0, 15);
            bus_wr(A(ch + 1, 16 + i), 16'(tab[i]));
         end
         bus_wr(A(ch + 1, 0), 16'((last << 4) | (size & 15)));
         bus_wr(A(ch + 1, 3), 16'(dly));
         bus_wr(A(ch + 1, 5), 16'(tgt));
         bus_wr(A(ch + 1, 1), 16'(oe));
         bus_wr(A(0, 3), 16'(1 << ch));
         bus_wr(A(0, 1), 16'(1 << ch));
         repeat (tgt * (dly + 1) - 1) @(negedge clk);
         check("rnd_irq_early", 32'(irq), 0);
         @(negedge clk);
         check("rnd_irq", 32'(irq), 1);
         idx = (((tgt * size) % last) + last) % last;
         check("rnd_mc", 32'(mc[ch*4 +: 4]), tab[idx]);
         check("rnd_oe", 32'(mc_oe[ch*4 +: 4]), oe);
         read_pos(ch, p);         check("rnd_pos", p, 32'(tgt * size));
         bus_rd(A(ch + 1, 8), d); check("rnd_stat", 32'(d), idx);
         bus_rd(A(0, 2), d);      check("rnd_done", 32'(d), 1 << ch);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
